// File: rtl/trng_pkg.sv
// Shared types and default thresholds for the TRNG post-processing block.
package trng_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2,
      ST_ALARM  = 2'd3
   } trng_state_t;

   localparam int DEF_WORD_W     = 32;
   localparam int DEF_WARMUP     = 256;
   localparam int DEF_RCT_CUTOFF = 34;
   localparam int DEF_APT_WINDOW = 1024;
   localparam int DEF_APT_CUTOFF = 589;

endpackage

// File: rtl/trng_health_test.sv
// Repetition-count and adaptive-proportion health tests on the raw bitstream.
// fail_o is combinational on the sample being presented this cycle.
module trng_health_test
   import trng_pkg::*;
#(
   parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW = DEF_APT_WINDOW,
   parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_i,
   input  logic sample_en_i,
   input  logic restart_i,
   output logic fail_o
);

   localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
   localparam int WIN_W = $clog2(APT_WINDOW);
   localparam int APT_W = $clog2(APT_WINDOW + 1);
   localparam logic [RCT_W-1:0] RCT_MAX = RCT_W'(RCT_CUTOFF);
   localparam logic [APT_W-1:0] APT_MAX = APT_W'(APT_CUTOFF);

   logic             last_q, last_d;
   logic [RCT_W-1:0] run_cnt_q, run_cnt_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic             ref_q, ref_d;
   logic [APT_W-1:0] apt_cnt_q, apt_cnt_d;

   always_comb begin
      last_d    = last_q;
      run_cnt_d = run_cnt_q;
      win_cnt_d = win_cnt_q;
      ref_d     = ref_q;
      apt_cnt_d = apt_cnt_q;
      fail_o    = 1'b0;
      if (restart_i) begin
         last_d    = 1'b0;
         run_cnt_d = '0;
         win_cnt_d = '0;
         ref_d     = 1'b0;
         apt_cnt_d = '0;
      end else if (sample_en_i) begin
         last_d = sample_i;
         // run_cnt==0 means no previous sample since restart
         if (run_cnt_q == '0 || sample_i != last_q) begin
            run_cnt_d = RCT_W'(1);
         end else if (run_cnt_q != RCT_MAX) begin
            run_cnt_d = run_cnt_q + 1'b1;
         end
         if (win_cnt_q == '0) begin
            ref_d     = sample_i;
            apt_cnt_d = APT_W'(1);
         end else if (sample_i == ref_q) begin
            apt_cnt_d = apt_cnt_q + 1'b1;
         end
         win_cnt_d = win_cnt_q + 1'b1;
         fail_o    = (run_cnt_d == RCT_MAX) || (apt_cnt_d == APT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q    <= 1'b0;
         run_cnt_q <= '0;
         win_cnt_q <= '0;
         ref_q     <= 1'b0;
         apt_cnt_q <= '0;
      end else begin
         last_q    <= last_d;
         run_cnt_q <= run_cnt_d;
         win_cnt_q <= win_cnt_d;
         ref_q     <= ref_d;
         apt_cnt_q <= apt_cnt_d;
      end
   end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processor: warm-up/run/alarm FSM, Von Neumann debiasing and word packing.
// Output handshake: a word transfers on a clk edge where rd_valid & rd_ready; rd_data holds while rd_valid & !rd_ready.
module trng_postproc
   import trng_pkg::*;
#(
   parameter int WORD_W     = DEF_WORD_W,
   parameter int WARMUP     = DEF_WARMUP,
   parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW = DEF_APT_WINDOW,
   parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              raw_bit,
   input  logic              clear_alarm,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              alarm,
   output logic              busy,
   output trng_state_t       dbg_state_o
);

   localparam int WARM_W = $clog2(WARMUP);
   localparam int CNT_W  = $clog2(WORD_W + 1);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
   localparam logic [CNT_W-1:0]  FULL      = CNT_W'(WORD_W);

   trng_state_t       state_q, state_d;
   logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
   logic              pair_phase_q, pair_phase_d;
   logic              pair_first_q, pair_first_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   logic              hlth_fail;
   logic              emit_v;
   logic              emit_bit;
   logic              out_free;
   logic [WORD_W-1:0] word_shift;

   trng_health_test #(
      .RCT_CUTOFF (RCT_CUTOFF),
      .APT_WINDOW (APT_WINDOW),
      .APT_CUTOFF (APT_CUTOFF)
   ) u_health (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_i    (raw_bit),
      .sample_en_i (state_q == ST_RUN),
      .restart_i   (state_q != ST_RUN),
      .fail_o      (hlth_fail)
   );

   // Pair phase drops back to 0 whenever we are not cleanly continuing RUN.
   always_comb begin
      pair_phase_d = 1'b0;
      pair_first_d = pair_first_q;
      emit_v       = 1'b0;
      emit_bit     = pair_first_q;
      if (state_q == ST_RUN && enable && !hlth_fail) begin
         if (!pair_phase_q) begin
            pair_phase_d = 1'b1;
            pair_first_d = raw_bit;
         end else begin
            emit_v = (pair_first_q != raw_bit);
         end
      end
   end

   assign out_free   = !rd_valid_q || rd_ready;
   assign word_shift = {emit_bit, word_q[WORD_W-1:1]};

   always_comb begin
      state_d    = state_q;
      warm_cnt_d = '0;
      word_d     = word_q;
      bit_cnt_d  = bit_cnt_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_valid_q && !rd_ready;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (warm_cnt_q == WARM_LAST) begin
               state_d = ST_RUN;
            end else begin
               warm_cnt_d = warm_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d   = ST_IDLE;
               word_d    = '0;
               bit_cnt_d = '0;
            end else if (hlth_fail) begin
               state_d    = ST_ALARM;
               word_d     = '0;
               bit_cnt_d  = '0;
               rd_valid_d = 1'b0;
            end else if (bit_cnt_q == FULL) begin
               // Held word goes out as soon as the output slot frees; bits emitted meanwhile are lost.
               if (out_free) begin
                  rd_data_d  = word_q;
                  rd_valid_d = 1'b1;
                  bit_cnt_d  = '0;
               end
            end else if (emit_v) begin
               if (bit_cnt_q == FULL - 1'b1) begin
                  if (out_free) begin
                     rd_data_d  = word_shift;
                     rd_valid_d = 1'b1;
                     bit_cnt_d  = '0;
                  end else begin
                     word_d    = word_shift;
                     bit_cnt_d = FULL;
                  end
               end else begin
                  word_d    = word_shift;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_ALARM: begin
            if (clear_alarm) state_d = enable ? ST_WARMUP : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         warm_cnt_q   <= '0;
         pair_phase_q <= 1'b0;
         pair_first_q <= 1'b0;
         word_q       <= '0;
         bit_cnt_q    <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         warm_cnt_q   <= warm_cnt_d;
         pair_phase_q <= pair_phase_d;
         pair_first_q <= pair_first_d;
         word_q       <= word_d;
         bit_cnt_q    <= bit_cnt_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
      end
   end

   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign alarm       = (state_q == ST_ALARM);
   assign busy        = (state_q == ST_WARMUP) || (state_q == ST_RUN);
   assign dbg_state_o = state_q;

endmodule
